// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_ctrl slice: FSM states, latency bound,
// and the byte-enable merge used by the storage write path.
package ram_pkg;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam int RD_LAT_MAX = 4;
  localparam int DATA_W_MAX = 128;

  typedef logic [DATA_W_MAX-1:0]   word_t;
  typedef logic [DATA_W_MAX/8-1:0] be_t;

  // Narrower words are zero-extended into word_t by the caller.
  function automatic word_t be_merge(word_t old, word_t wdata, be_t be);
    word_t res;
    res = old;
    for (int i = 0; i < DATA_W_MAX/8; i++)
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/ram_array.sv
// DEPTH x DATA_W single-port storage, byte-enabled writes, 1-cycle registered read.
// No reset: contents are defined by the controller's clear sequence.
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] merged;

  assign merged = DATA_W'(be_merge(word_t'(mem[addr]), word_t'(wdata), be_t'(be)));

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= merged;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// Valid/ready front end for ram_array: post-reset clear FSM, range checking and
// a fixed-latency read response pipeline.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT    = (RD_LAT < 1) ? 1 : (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int STAGES = LAT - 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [AW-1:0]     clr_cnt;
  logic              acc, rd_acc, in_range, init_wr;
  logic              arr_en, arr_we;
  logic [AW-1:0]     arr_addr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic [DATA_W/8-1:0] arr_be;
  logic [STAGES:0]   vld_pipe, err_pipe;
  logic [DATA_W-1:0] d0, dout;

  assign req_ready = (state == ST_READY);
  assign init_done = (state == ST_READY);

  // Full-width compare: no aliasing of out-of-range addresses onto real words.
  assign in_range = {1'b0, req_addr} < DEPTH_X;
  assign acc      = req_valid && req_ready && rst_n;
  assign rd_acc   = acc && !req_we;
  assign init_wr  = (state == ST_INIT) && (CLEAR_ON_RST != 0) && rst_n;

  assign arr_en    = init_wr || (acc && in_range);
  assign arr_we    = init_wr || req_we;
  assign arr_addr  = init_wr ? clr_cnt : req_addr[AW-1:0];
  assign arr_wdata = init_wr ? '0 : req_wdata;
  assign arr_be    = init_wr ? '1 : req_be;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (CLEAR_ON_RST == 0 || clr_cnt == AW'(DEPTH-1)) state <= ST_READY;
      clr_cnt <= clr_cnt + AW'(1);
    end
  end

  ram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Stage 0 is the array's own output register; later stages only delay it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      err_pipe[0] <= !in_range;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
      end
    end
  end

  assign d0 = err_pipe[0] ? '0 : arr_rdata;

  if (STAGES == 0) begin : g_nopipe
    assign dout = d0;
  end else begin : g_pipe
    logic [STAGES:1][DATA_W-1:0] dq;
    always_ff @(posedge clk) begin
      dq[1] <= d0;
      for (int i = 2; i <= STAGES; i++) dq[i] <= dq[i-1];
    end
    assign dout = dq[STAGES];
  end

  assign rsp_valid = vld_pipe[STAGES];
  assign rsp_err   = vld_pipe[STAGES] && err_pipe[STAGES];
  assign rsp_data  = rsp_valid ? dout : '0;

endmodule

// File: tb/tb_ram_ctrl.sv
// Three ram_ctrl configurations driven by a shared request stream and checked
// against a transaction-level model (word array plus timed response queue).
module tb_ram_ctrl;

  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_we;
  logic [7:0]        req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_be;
  logic [N-1:0]      rdy, rv, re, dn;
  logic [N-1:0][15:0] rd;

  always #5 clk = ~clk;

  ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .CLEAR_ON_RST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[0]),
    .rsp_data(rd[0]), .rsp_err(re[0]), .init_done(dn[0]));
  ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(3), .CLEAR_ON_RST(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[1]),
    .rsp_data(rd[1]), .rsp_err(re[1]), .init_done(dn[1]));
  ram_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(4), .CLEAR_ON_RST(1)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[2]),
    .rsp_data(rd[2]), .rsp_err(re[2]), .init_done(dn[2]));

  typedef struct {
    int          dut;
    int          due;
    logic [15:0] data;
    logic [15:0] m;
    logic        err;
  } rsp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          ecnt [N];
  logic [15:0] mem  [N][256];
  logic [1:0]  km   [N][256];
  rsp_t        q [$];
  logic [N-1:0] obs_v, obs_e, seen_v;
  logic [N-1:0][15:0] obs_d;

  function automatic int dep(int d);  return (d == 0) ? 256 : 200; endfunction
  function automatic int lat(int d);  return (d == 0) ? 1 : (d == 1) ? 3 : 4; endfunction
  function automatic bit clr(int d);  return d != 1; endfunction
  function automatic bit mready(int d);
    return ecnt[d] >= (clr(d) ? dep(d) : 1);
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // Effect of the coming clock edge on the model of one configuration.
  task automatic model_edge(int d);
    rsp_t e;
    int   a;
    if (!rst_n) begin
      ecnt[d] = 0;
      for (int w = 0; w < 256; w++) km[d][w] = 2'b00;
      return;
    end
    a = int'(req_addr);
    if (mready(d) && req_valid) begin
      if (req_we) begin
        if (a < dep(d))
          for (int b = 0; b < 2; b++)
            if (req_be[b]) begin
              mem[d][a][8*b +: 8] = req_wdata[8*b +: 8];
              km[d][a][b] = 1'b1;
            end
      end else begin
        e.dut = d;
        e.due = cyc + lat(d);
        e.err = (a >= dep(d));
        e.data = e.err ? 16'h0 : mem[d][a];
        e.m = e.err ? 16'hFFFF : {{8{km[d][a][1]}}, {8{km[d][a][0]}}};
        q.push_back(e);
      end
    end
    if (ecnt[d] < 1000000) ecnt[d]++;
    if (clr(d) && ecnt[d] == dep(d))
      for (int w = 0; w < dep(d); w++) begin
        mem[d][w] = 16'h0;
        km[d][w]  = 2'b11;
      end
  endtask

  task automatic check_out(int d);
    int   idx;
    rsp_t e;
    idx = -1;
    for (int i = 0; i < q.size(); i++)
      if (q[i].dut == d) begin idx = i; break; end
    obs_v[d] = rv[d];
    obs_d[d] = rd[d];
    obs_e[d] = re[d];
    if (rv[d]) seen_v[d] = 1'b1;
    chk($sformatf("ready%0d", d), 32'(rdy[d]), 32'(mready(d)));
    chk($sformatf("init_done%0d", d), 32'(dn[d]), 32'(mready(d)));
    if (idx >= 0 && q[idx].due == cyc) begin
      e = q[idx];
      q.delete(idx);
      chk($sformatf("rsp_valid%0d", d), 32'(rv[d]), 32'd1);
      chk($sformatf("rsp_err%0d", d), 32'(re[d]), 32'(e.err));
      if (e.m != 16'h0)
        chk($sformatf("rsp_data%0d", d), 32'(rd[d] & e.m), 32'(e.data & e.m));
    end else begin
      chk($sformatf("rsp_valid_idle%0d", d), 32'(rv[d]), 32'd0);
      chk($sformatf("rsp_data_idle%0d", d), 32'(rd[d]), 32'd0);
      chk($sformatf("rsp_err_idle%0d", d), 32'(re[d]), 32'd0);
    end
  endtask

  task automatic step();
    for (int d = 0; d < N; d++) model_edge(d);
    if (!rst_n) q.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int d = 0; d < N; d++) check_out(d);
  endtask

  task automatic req(bit v, bit we, logic [7:0] a, logic [15:0] w, logic [1:0] be);
    req_valid = v; req_we = we; req_addr = a; req_wdata = w; req_be = be;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 8'h00, 16'h0, 2'b00);
  endtask

  task automatic rand_traffic(int n);
    for (int i = 0; i < n; i++)
      req(($urandom % 4) != 0, $urandom % 2,
          8'(($urandom % 4 == 0) ? $urandom_range(190, 255) : $urandom_range(0, 31)),
          16'($urandom), 2'($urandom));
  endtask

  initial begin
    int n, n2;
    logic r1_first;
    for (int d = 0; d < N; d++) ecnt[d] = 0;
    seen_v = '0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    @(negedge clk);
    idle(3);

    // Clear sequence: count edges after release until each config is ready.
    rst_n = 1'b1;
    n = 0; n2 = 0; r1_first = 1'b0;
    while (!rdy[0] && n < 400) begin
      idle(1);
      n++;
      if (n == 1) r1_first = rdy[1];
      if (rdy[2] && n2 == 0) n2 = n;
    end
    chk("clr_cycles_256", 32'(n), 32'd256);
    chk("clr_cycles_200", 32'(n2), 32'd200);
    chk("noclr_first_ready", 32'(r1_first), 32'd1);

    req(1'b1, 1'b0, 8'h00, 16'h0, 2'b00);
    chk("clr_rd00", {15'd0, obs_v[0], obs_d[0]}, 32'h0001_0000);
    req(1'b1, 1'b0, 8'h7F, 16'h0, 2'b00);
    chk("clr_rd7f", {15'd0, obs_v[0], obs_d[0]}, 32'h0001_0000);
    req(1'b1, 1'b0, 8'hFF, 16'h0, 2'b00);
    chk("clr_rdff", {14'd0, obs_v[0], obs_e[0], obs_d[0]}, 32'h0002_0000);
    idle(5);

    req(1'b1, 1'b1, 8'h10, 16'hABCD, 2'b11);
    req(1'b1, 1'b1, 8'h10, 16'h1200, 2'b10);
    req(1'b1, 1'b0, 8'h10, 16'h0, 2'b00);
    chk("be_merge", 32'(obs_d[0]), 32'h12CD);
    idle(5);

    req(1'b1, 1'b1, 8'h05, 16'h1111, 2'b11);
    req(1'b1, 1'b1, 8'h06, 16'h2222, 2'b11);
    req(1'b1, 1'b0, 8'h05, 16'h0, 2'b00);
    req(1'b1, 1'b0, 8'h06, 16'h0, 2'b00);
    chk("lat3_early", 32'(obs_v[1]), 32'd0);
    idle(1);
    chk("lat3_first", {15'd0, obs_v[1], obs_d[1]}, 32'h0001_1111);
    idle(1);
    chk("lat3_second", {15'd0, obs_v[1], obs_d[1]}, 32'h0001_2222);
    idle(5);

    req(1'b1, 1'b1, 8'hC8, 16'h5555, 2'b11);
    req(1'b1, 1'b0, 8'hC8, 16'h0, 2'b00);
    req(1'b1, 1'b0, 8'hC7, 16'h0, 2'b00);
    idle(1);
    chk("oor_lat3", {14'd0, obs_v[1], obs_e[1], obs_d[1]}, 32'h0003_0000);
    idle(1);
    chk("oor_lat4", {14'd0, obs_v[2], obs_e[2], obs_d[2]}, 32'h0003_0000);
    idle(1);
    chk("inr_c7", {14'd0, obs_v[2], obs_e[2], obs_d[2]}, 32'h0002_0000);
    idle(5);

    rand_traffic(1500);
    idle(6);

    // Reset with two reads in flight in the RD_LAT=4 configuration.
    seen_v = '0;
    req(1'b1, 1'b0, 8'h03, 16'h0, 2'b00);
    req(1'b1, 1'b0, 8'h04, 16'h0, 2'b00);
    rst_n = 1'b0;
    idle(2);
    chk("mf_done_low", 32'(dn[2]), 32'd0);
    rst_n = 1'b1;
    n = 0; n2 = 0;
    while (!rdy[0] && n < 400) begin
      idle(1);
      n++;
      if (dn[2] && n2 == 0) n2 = n;
    end
    chk("mf_no_rsp", 32'(seen_v[2]), 32'd0);
    chk("mf_reclear_200", 32'(n2), 32'd200);
    chk("mf_reclear_256", 32'(n), 32'd256);

    rand_traffic(600);
    idle(6);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
Parametrised single-port synchronous RAM with a valid/ready request interface and a fixed-latency read response pipeline. It supersedes the free-running, self-clocked 16x256 memory. It runs on the system clock, clears its contents after reset, and supports byte-enabled writes and configurable read latency. It sits between the CPU load/store unit and the storage array.

Parameters:
DATA_W, 16, data word width in bits (multiple of 8)
ADDR_W, 8, request address width
DEPTH, 256, number of words (must be <= 2**ADDR_W; need not be a power of two)
RD_LAT, 1, read latency in cycles from accept to rsp_valid (legal range 1..4)
CLEAR_ON_RST, 1, 1 = zero every word after reset; 0 = skip the INIT state

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte enables for writes; ignored on reads
rsp_valid  out  1  read data valid (1-cycle pulse per read)
rsp_data  out  DATA_W  read data; 0 whenever rsp_valid=0
rsp_err  out  1  qualifies rsp_valid: the read address was >= DEPTH
init_done  out  1  high once the clear sequence has finished

Behaviour:
- Reset (rst_n=0 at a clk edge): req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0. All read pipeline stages are flushed. Memory contents are unspecified until INIT completes.
- FSM states:
  - INIT: entered from reset when CLEAR_ON_RST=1. Clear counter starts at 0 and writes 0 to one word per cycle, DEPTH cycles in total. After word DEPTH-1 is written, go to READY. req_ready=0 throughout INIT.
  - READY: entered directly from reset when CLEAR_ON_RST=0. init_done=1 and req_ready=1 every cycle. There is no stall source.
- First acceptance timing with CLEAR_ON_RST=1: deassert rst_n at edge E. init_done and req_ready rise after edge E+DEPTH. The first request can be accepted at edge E+DEPTH+1.
- Accept rule: a request is accepted on a clk edge where req_valid && req_ready. One request per cycle, back-to-back allowed.
- Write:
  - Byte i of word addr is updated with req_wdata[8i+7:8i] when req_be[i]=1. Unselected bytes are preserved.
  - A write with req_be=0 is a no-op.
  - A write with addr >= DEPTH is silently dropped and produces no response.
- Read:
  - A read accepted at edge N produces rsp_valid=1 for exactly the cycle following edge N+RD_LAT-1. RD_LAT=1 means the data is visible the cycle after accept.
  - A read with addr >= DEPTH returns rsp_data=0 and rsp_err=1 at the same latency.
  - A read of an address written at an earlier edge returns the new data. For a write at edge N and a read of the same address at edge N+1, the read returns the written data.
- Responses come back in request order. The number of reads in flight is at most RD_LAT.
- Reset during READY with reads in flight: those reads never produce rsp_valid.
- Reset during INIT: the clear counter restarts at 0.
- Out-of-range checks use a full-width compare of req_addr against DEPTH. There is no address wrap.

Decomposition:
- Package ram_pkg holds:
  - the state enum {ST_INIT, ST_READY};
  - the constant RD_LAT_MAX=4;
  - a function be_merge(old, wdata, be) used by the write path.
- One sub-module, ram_array: DEPTH x DATA_W storage with a single synchronous port (en, we, be, addr, wdata, rdata) and 1-cycle read. It has no reset.
- ram_ctrl adds the FSM, the clear counter, range checking, and an RD_LAT-1 stage valid/err/data delay pipeline after ram_array.

Test Plan:
- Clear sequence: reset, then wait for init_done. Expect exactly 256 cycles with req_ready=0. Then read addr 0x00, 0x7F and 0xFF; each returns 0x0000 with rsp_err=0.
- Byte-enable write: write 0xABCD be=2'b11 to 0x10, then 0x1200 be=2'b10 to 0x10, then read 0x10. Expect 0x12CD one cycle after accept (RD_LAT=1).
- Back-to-back traffic with RD_LAT=3: write 0x1111 to 0x05, write 0x2222 to 0x06, then read 0x05 and read 0x06 on consecutive cycles. Expect rsp_valid on 2 consecutive cycles, 3 cycles after each accept, with data 0x1111 then 0x2222.
- Out of range with DEPTH=200, ADDR_W=8: write 0x5555 to 0xC8, then read 0xC8. Expect rsp_err=1 and rsp_data=0. A read of 0xC7 returns 0x0000 with rsp_err=0.
- Reset mid-flight with RD_LAT=4: accept 2 reads, then assert rst_n=0 one cycle later. rsp_valid must never assert, and init_done must fall and later re-rise after a full DEPTH-cycle clear.
- CLEAR_ON_RST=0: req_ready=1 on the first cycle after reset release. A write followed by a read of 0x33 returns the written value.
